demux1ton_reg: RTL and testbench

Registered 1-to-N demultiplexor with valid/ready handshaking on every port, in the reverse direction of the MIPS-C select-N-to-1 multiplexors. It steers one producer stream, such as a result or writeback word, to one of `NUM_OUT` consumer channels chosen by a per-word select. Each output channel has its own one-entry holding register, so a stalled consumer blocks only words addressed to it.

---
 rtl/demux1ton_reg.sv | 81 ++++++++
 tb/tb_demux1ton_reg.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/demux1ton_reg.sv
// Registered 1-to-N demultiplexor with valid/ready on every port.
// Each output channel has its own one-entry holding register, so a stalled consumer blocks only its own words.

module demux1ton_reg_chan #(
  parameter int WIDTH_DATA = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [WIDTH_DATA-1:0] din,
  input  logic                  rdy,
  output logic [WIDTH_DATA-1:0] data,
  output logic                  vld
);
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
      vld  <= 1'b0;
    end else if (load) begin
      // covers load-only and load-with-drain: valid stays set
      data <= din;
      vld  <= 1'b1;
    end else if (vld && rdy) begin
      vld  <= 1'b0;
    end
  end
endmodule

module demux1ton_reg #(
  parameter int WIDTH_DATA = 32,
  parameter int NUM_OUT    = 7,
  parameter int WIDTH_SEL  = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WIDTH_DATA-1:0]         in_data,
  input  logic [WIDTH_SEL-1:0]          in_sel,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [NUM_OUT*WIDTH_DATA-1:0] out_data,
  output logic [NUM_OUT-1:0]            out_valid,
  input  logic [NUM_OUT-1:0]            out_ready,
  output logic                          bad_sel
);
  localparam logic [WIDTH_SEL:0] NUM_OUT_W = (WIDTH_SEL+1)'(NUM_OUT);

  logic                 sel_ok;
  logic [WIDTH_SEL-1:0] sel_eff;
  logic [NUM_OUT-1:0]   hit;
  logic [NUM_OUT-1:0]   load;
  logic                 accept;

  // out-of-range selects fall back to channel 0
  assign sel_ok   = ({1'b0, in_sel} < NUM_OUT_W);
  assign sel_eff  = sel_ok ? in_sel : '0;
  assign in_ready = |(hit & (~out_valid | out_ready));
  assign accept   = in_valid & in_ready;

  genvar k;
  generate
    for (k = 0; k < NUM_OUT; k++) begin : g_ch
      assign hit[k]  = (sel_eff == WIDTH_SEL'(k));
      assign load[k] = accept & hit[k];

      demux1ton_reg_chan #(.WIDTH_DATA(WIDTH_DATA)) u_ch (
        .clk  (clk),
        .rst  (rst),
        .load (load[k]),
        .din  (in_data),
        .rdy  (out_ready[k]),
        .data (out_data[k*WIDTH_DATA +: WIDTH_DATA]),
        .vld  (out_valid[k])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) bad_sel <= 1'b0;
    else     bad_sel <= accept & ~sel_ok;
  end
endmodule

// File: tb/tb_demux1ton_reg.sv
// Bench for demux1ton_reg: per-channel expected-word queues plus a vector table and directed corner sequences.

module tb_demux1ton_reg;
  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  in_data;
  logic [2:0]   in_sel;
  logic         in_valid;
  logic         in_ready;
  logic [223:0] out_data;
  logic [6:0]   out_valid;
  logic [6:0]   out_ready;
  logic         bad_sel;

  logic         in_valid5;
  logic         in_ready5;
  logic [159:0] out_data5;
  logic [4:0]   out_valid5;
  logic [4:0]   out_ready5;
  logic         bad_sel5;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] q [7][$];

  always #5 clk = ~clk;

  demux1ton_reg #(.WIDTH_DATA(32), .NUM_OUT(7), .WIDTH_SEL(3)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .bad_sel(bad_sel)
  );

  demux1ton_reg #(.WIDTH_DATA(32), .NUM_OUT(5), .WIDTH_SEL(3)) dut5 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid5),
    .in_ready(in_ready5), .out_data(out_data5), .out_valid(out_valid5),
    .out_ready(out_ready5), .bad_sel(bad_sel5)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // One clock: check handshake against the queue model, score drains, then check registered outputs.
  task automatic cyc();
    int          se;
    logic        exp_rdy;
    logic        acc;
    logic        exp_bad;
    logic [31:0] w;
    logic [6:0]  exp_ov;
    #1;
    se      = (in_sel < 3'd7) ? int'(in_sel) : 0;
    exp_rdy = (q[se].size() == 0) || out_ready[se];
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    acc     = in_valid && exp_rdy;
    exp_bad = !rst && acc && (in_sel >= 3'd7);
    for (int k = 0; k < 7; k++)
      if (q[k].size() != 0 && out_ready[k]) begin
        w = q[k].pop_front();
        chk("drain_data", out_data[k*32 +: 32], w);
      end
    if (rst) begin
      for (int k = 0; k < 7; k++) q[k].delete();
    end else if (acc) begin
      q[se].push_back(in_data);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 7; k++) exp_ov[k] = (q[k].size() != 0);
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    chk("bad_sel", 32'(bad_sel), 32'(exp_bad));
  endtask

  typedef struct {
    logic        vld;
    logic [2:0]  sel;
    logic [31:0] d;
    logic [6:0]  ordy;
    logic        rdy;
    logic [6:0]  ov;
    logic        cen;
    int          ch;
    logic [31:0] cd;
  } vec_t;

  vec_t tv[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // single word, backpressure, channel isolation
    tv.push_back('{1'b1, 3'd3, 32'h1234_5678, 7'h7F, 1'b1, 7'h08, 1'b1, 3, 32'h1234_5678});
    tv.push_back('{1'b0, 3'd3, 32'h0,         7'h7F, 1'b1, 7'h00, 1'b0, 0, 32'h0});
    tv.push_back('{1'b1, 3'd2, 32'hAAAA_0001, 7'h7B, 1'b1, 7'h04, 1'b1, 2, 32'hAAAA_0001});
    for (int i = 0; i < 5; i++)
      tv.push_back('{1'b1, 3'd2, 32'hAAAA_0002, 7'h7B, 1'b0, 7'h04, 1'b1, 2, 32'hAAAA_0001});
    tv.push_back('{1'b1, 3'd2, 32'hAAAA_0002, 7'h7F, 1'b1, 7'h04, 1'b1, 2, 32'hAAAA_0002});
    tv.push_back('{1'b0, 3'd2, 32'h0,         7'h7F, 1'b1, 7'h00, 1'b0, 0, 32'h0});
    tv.push_back('{1'b1, 3'd1, 32'h0000_00C1, 7'h7D, 1'b1, 7'h02, 1'b1, 1, 32'h0000_00C1});
    tv.push_back('{1'b1, 3'd5, 32'h0000_00C5, 7'h7D, 1'b1, 7'h22, 1'b1, 5, 32'h0000_00C5});
    tv.push_back('{1'b0, 3'd1, 32'h0,         7'h7D, 1'b0, 7'h02, 1'b1, 1, 32'h0000_00C1});
    tv.push_back('{1'b0, 3'd0, 32'h0,         7'h7F, 1'b1, 7'h00, 1'b0, 0, 32'h0});

    rst = 1'b1; in_valid = 1'b0; in_valid5 = 1'b0; in_sel = '0; in_data = '0;
    out_ready = '0; out_ready5 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_bad_sel", 32'(bad_sel), 32'h0);
    for (int k = 0; k < 7; k++) chk("rst_out_data", out_data[k*32 +: 32], 32'h0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'h1);

    foreach (tv[i]) begin
      in_valid = tv[i].vld; in_sel = tv[i].sel; in_data = tv[i].d; out_ready = tv[i].ordy;
      #1;
      chk("tv_in_ready", 32'(in_ready), 32'(tv[i].rdy));
      cyc();
      chk("tv_out_valid", 32'(out_valid), 32'(tv[i].ov));
      if (tv[i].cen) chk("tv_ch_data", out_data[tv[i].ch*32 +: 32], tv[i].cd);
    end

    // full rate, alternating channels
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_sel = 3'(i % 2); in_data = 32'(i); out_ready = 7'h7F;
      cyc();
      chk("stream_data", out_data[(i%2)*32 +: 32], 32'(i));
    end
    in_valid = 1'b0;
    cyc();

    // illegal select on the 7-channel block goes to channel 0 and pulses bad_sel
    in_valid = 1'b1; in_sel = 3'd7; in_data = 32'h0000_0077; out_ready = 7'h7F;
    cyc();
    chk("sel7_ch0", out_data[31:0], 32'h0000_0077);
    in_valid = 1'b0;
    cyc();

    // illegal select on the 5-channel block
    in_valid5 = 1'b1; in_sel = 3'd6; in_data = 32'hDEAD_BEEF; out_ready5 = 5'h00;
    #1;
    chk("n5_in_ready", 32'(in_ready5), 32'h1);
    cyc();
    chk("n5_ch0", out_data5[31:0], 32'hDEAD_BEEF);
    chk("n5_out_valid", 32'(out_valid5), 32'h01);
    chk("n5_bad_sel", 32'(bad_sel5), 32'h1);
    in_valid5 = 1'b0; out_ready5 = 5'h1F;
    cyc();
    chk("n5_bad_sel_drop", 32'(bad_sel5), 32'h0);
    chk("n5_drained", 32'(out_valid5), 32'h0);

    // reset while channels 0, 4, 6 hold stalled words and an accept is offered
    out_ready = 7'h00; in_valid = 1'b1;
    in_sel = 3'd0; in_data = 32'h0000_00A0; cyc();
    in_sel = 3'd4; in_data = 32'h0000_00A4; cyc();
    in_sel = 3'd6; in_data = 32'h0000_00A6; cyc();
    chk("pre_rst_valid", 32'(out_valid), 32'h51);
    rst = 1'b1; in_sel = 3'd7; in_data = 32'hFFFF_FFFF; out_ready = 7'h01;
    cyc();
    rst = 1'b0; in_valid = 1'b0; in_sel = 3'd0; out_ready = 7'h00;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_bad", 32'(bad_sel), 32'h0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'h1);
    for (int k = 0; k < 7; k++) chk("mid_rst_data", out_data[k*32 +: 32], 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
